// File: rtl/dbg_uart_pkg.sv
// Shared definitions for the debug UART escaping transmitter/receiver pair.
package dbg_uart_pkg;
  localparam logic [7:0] ESC_DEFAULT = 8'hB1;

  typedef enum logic {IDLE, ESC_SEEN} rx_esc_state_e;
endpackage

// File: rtl/rx_escape_if.sv
// Byte stream from UART-RX in, de-escaped data/command stream out toward TAP/DMI.
interface rx_escape_if;
  logic       rx_valid;
  logic [7:0] data_in;
  logic       read;
  logic [7:0] data_rec;
  logic       data_valid;
  logic [7:0] command;
  logic       command_valid;
  logic       esc_pending;
  logic       overrun;
  logic       timeout;

  modport master (
    output rx_valid, data_in, read,
    input  data_rec, data_valid, command, command_valid, esc_pending, overrun, timeout
  );
  modport slave (
    input  rx_valid, data_in, read,
    output data_rec, data_valid, command, command_valid, esc_pending, overrun, timeout
  );
endinterface

// File: rtl/rx_escape.sv
// Strips ESC sequences from the UART-RX byte stream: ESC ESC -> literal data,
// ESC x -> command x. One-entry data holding register, dangling-ESC timeout.
module rx_escape
  import dbg_uart_pkg::*;
#(
  parameter logic [7:0] ESC            = ESC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       RX_VALID_I,
  input  logic [7:0] DATA_REC_I,
  input  logic       READ_I,
  output logic [7:0] DATA_REC_O,
  output logic       DATA_VALID_O,
  output logic [7:0] COMMAND_O,
  output logic       COMMAND_VALID_O,
  output logic       ESC_PENDING_O,
  output logic       OVERRUN_O,
  output logic       TIMEOUT_O
);
  // Width floored at 1 so a disabled timeout still yields a legal counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  rx_esc_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             dvalid_q, dvalid_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             cmdv_q, cmdv_d;
  logic             ovr_q, ovr_d;
  logic             to_q, to_d;

  logic is_esc;
  logic deliver;

  assign is_esc = (DATA_REC_I == ESC);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    cmdv_d   = 1'b0;
    to_d     = 1'b0;
    deliver  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RX_VALID_I) begin
          if (is_esc) begin
            state_d = ESC_SEEN;
            cnt_d   = '0;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      ESC_SEEN: begin
        if (RX_VALID_I) begin
          state_d = IDLE;
          if (is_esc) begin
            deliver = 1'b1;
          end else begin
            cmd_d  = DATA_REC_I;
            cmdv_d = 1'b1;
          end
        end else if (TO_EN) begin
          if (cnt_q == CNT_TERM) begin
            state_d = IDLE;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A read in the same cycle frees the slot, so delivery then never overruns.
  always_comb begin
    data_d   = data_q;
    dvalid_d = dvalid_q;
    ovr_d    = 1'b0;
    if (deliver) begin
      if (!dvalid_q || READ_I) begin
        data_d   = DATA_REC_I;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (READ_I && dvalid_q) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      cmd_q    <= '0;
      cmdv_q   <= 1'b0;
      ovr_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      cmd_q    <= cmd_d;
      cmdv_q   <= cmdv_d;
      ovr_q    <= ovr_d;
      to_q     <= to_d;
    end
  end

  assign DATA_REC_O      = data_q;
  assign DATA_VALID_O    = dvalid_q;
  assign COMMAND_O       = cmd_q;
  assign COMMAND_VALID_O = cmdv_q;
  assign ESC_PENDING_O   = (state_q == ESC_SEEN);
  assign OVERRUN_O       = ovr_q;
  assign TIMEOUT_O       = to_q;
endmodule

// File: tb/tb_rx_escape.sv
// Directed-vector bench for rx_escape with an 8-cycle ESC timeout.
module tb_rx_escape;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pend_cnt;

  rx_escape_if bus ();

  rx_escape #(.ESC(8'hB1), .TIMEOUT_CYCLES(8)) dut (
    .CLK_I          (clk),
    .RST_NI         (rst_n),
    .RX_VALID_I     (bus.rx_valid),
    .DATA_REC_I     (bus.data_in),
    .READ_I         (bus.read),
    .DATA_REC_O     (bus.data_rec),
    .DATA_VALID_O   (bus.data_valid),
    .COMMAND_O      (bus.command),
    .COMMAND_VALID_O(bus.command_valid),
    .ESC_PENDING_O  (bus.esc_pending),
    .OVERRUN_O      (bus.overrun),
    .TIMEOUT_O      (bus.timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock, then let outputs settle 1 time unit after the edge.
  task automatic cyc(input logic rx, input logic [7:0] d, input logic rd);
    bus.rx_valid = rx;
    bus.data_in  = d;
    bus.read     = rd;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.data_in  = 8'h00;
    bus.read     = 1'b0;
  endtask

  task automatic chk_data(input string tag, input logic [7:0] d, input logic v);
    chk({tag, ".data"}, 32'(bus.data_rec), 32'(d));
    chk({tag, ".dvalid"}, 32'(bus.data_valid), 32'(v));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.data_in  = 8'h00;
    bus.read     = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.data", 32'(bus.data_rec), 0);
    chk("rst.dvalid", 32'(bus.data_valid), 0);
    chk("rst.cmd", 32'(bus.command), 0);
    chk("rst.flags", {28'd0, bus.command_valid, bus.esc_pending, bus.overrun, bus.timeout}, 0);
    rst_n = 1'b1;

    // Plain data
    cyc(1, 8'h41, 0); chk_data("d41", 8'h41, 1); chk("d41.cmdv", 32'(bus.command_valid), 0);
    cyc(0, 8'h00, 1); chk_data("rd41", 8'h41, 0);
    cyc(1, 8'h42, 0); chk_data("d42", 8'h42, 1); chk("d42.cmdv", 32'(bus.command_valid), 0);
    cyc(0, 8'h00, 1); chk_data("rd42", 8'h42, 0);

    // Escaped literal
    cyc(1, 8'hB1, 0); chk("lit.pend", 32'(bus.esc_pending), 1); chk("lit.dv0", 32'(bus.data_valid), 0);
    cyc(1, 8'hB1, 0); chk_data("lit", 8'hB1, 1);
    chk("lit.pend0", 32'(bus.esc_pending), 0); chk("lit.cmdv", 32'(bus.command_valid), 0);
    cyc(0, 8'h00, 1); chk("lit.rd", 32'(bus.data_valid), 0);

    // Command with empty holding register
    cyc(1, 8'hB1, 0);
    cyc(1, 8'h05, 0); chk("cmd.val", 32'(bus.command), 32'h05);
    chk("cmd.cmdv", 32'(bus.command_valid), 1); chk("cmd.dv", 32'(bus.data_valid), 0);
    cyc(0, 8'h00, 0); chk("cmd.pulse", 32'(bus.command_valid), 0); chk("cmd.hold", 32'(bus.command), 32'h05);

    // Command with held data byte: no overrun, data untouched
    cyc(1, 8'h77, 0); chk_data("h77", 8'h77, 1);
    cyc(1, 8'hB1, 0);
    cyc(1, 8'h06, 0); chk("cmd2.val", 32'(bus.command), 32'h06);
    chk("cmd2.cmdv", 32'(bus.command_valid), 1); chk("cmd2.ovr", 32'(bus.overrun), 0);
    chk_data("cmd2", 8'h77, 1);
    cyc(0, 8'h00, 1); chk("cmd2.rd", 32'(bus.data_valid), 0);

    // Overrun
    cyc(1, 8'h10, 0); chk_data("o10", 8'h10, 1);
    cyc(1, 8'h20, 0); chk("ovr.pulse", 32'(bus.overrun), 1); chk_data("ovr", 8'h10, 1);
    cyc(0, 8'h00, 0); chk("ovr.end", 32'(bus.overrun), 0);
    cyc(1, 8'h30, 1); chk("rdw.ovr", 32'(bus.overrun), 0); chk_data("rdw", 8'h30, 1);
    cyc(0, 8'h00, 1); chk("rdw.rd", 32'(bus.data_valid), 0);

    // Timeout: pending for exactly 8 cycles, then a one-cycle TIMEOUT_O
    pend_cnt = 0;
    cyc(1, 8'hB1, 0); if (bus.esc_pending) pend_cnt++;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 8'h00, 0);
      if (bus.esc_pending) pend_cnt++;
      chk("to.early", 32'(bus.timeout), 0);
    end
    chk("to.pendcnt", 32'(pend_cnt), 8);
    cyc(0, 8'h00, 0); chk("to.pend0", 32'(bus.esc_pending), 0); chk("to.pulse", 32'(bus.timeout), 1);
    cyc(1, 8'h05, 0); chk("to.end", 32'(bus.timeout), 0);
    chk_data("to.d05", 8'h05, 1); chk("to.cmdv", 32'(bus.command_valid), 0);
    cyc(0, 8'h00, 1);

    // Byte on the terminal-count cycle is still a command
    cyc(1, 8'hB1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 0);
    chk("term.pend", 32'(bus.esc_pending), 1);
    cyc(1, 8'h09, 0); chk("term.cmdv", 32'(bus.command_valid), 1); chk("term.cmd", 32'(bus.command), 32'h09);
    chk("term.to", 32'(bus.timeout), 0); chk("term.dv", 32'(bus.data_valid), 0);
    cyc(0, 8'h00, 0); chk("term.to2", 32'(bus.timeout), 0);

    // Reset mid-sequence
    cyc(1, 8'h99, 0);
    cyc(1, 8'hB1, 0); chk("mr.pend", 32'(bus.esc_pending), 1);
    rst_n = 1'b0;
    #1;
    chk("mr.async", {20'd0, bus.data_valid, bus.command_valid, bus.esc_pending, bus.overrun, bus.timeout,
                     7'd0}, 0);
    chk("mr.data", 32'(bus.data_rec), 0);
    chk("mr.cmd", 32'(bus.command), 0);
    @(posedge clk);
    #1;
    chk("mr.hold", {28'd0, bus.data_valid, bus.esc_pending, bus.command_valid, bus.timeout}, 0);
    rst_n = 1'b1;
    cyc(1, 8'h05, 0); chk_data("mr.d05", 8'h05, 1); chk("mr.cmdv", 32'(bus.command_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rx_escape.md
Name: rx_escape

Overview:
- Receive-side counterpart of the escaping transmitter. Sits between the UART-RX core and the TAP/DMI logic.
- Strips escape sequences from the incoming byte stream.
- ESC followed by ESC delivers a literal ESC data byte. ESC followed by any other byte delivers that byte as an out-of-band command.
- Holds one data byte for the TAP, flags overrun, and abandons a dangling ESC after a timeout.

Parameters:
- ESC, 8'hB1, escape byte value.
- TIMEOUT_CYCLES, 1000000, maximum cycles to wait for the byte following ESC; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), localparam, width of the timeout counter.

Ports:
- CLK_I  in  1  clock
- RST_NI  in  1  asynchronous active-low reset
- RX_VALID_I  in  1  single-cycle strobe from UART-RX: new byte on DATA_REC_I
- DATA_REC_I  in  8  received byte, valid only with RX_VALID_I
- READ_I  in  1  TAP consumes the held data byte
- DATA_REC_O  out  8  held data byte
- DATA_VALID_O  out  1  level: DATA_REC_O holds an unread byte
- COMMAND_O  out  8  last received command byte, held until the next command
- COMMAND_VALID_O  out  1  single-cycle pulse: new command on COMMAND_O
- ESC_PENDING_O  out  1  ESC received, awaiting the second byte
- OVERRUN_O  out  1  single-cycle pulse: data byte dropped
- TIMEOUT_O  out  1  single-cycle pulse: pending ESC abandoned

Behaviour:
- Reset (asynchronous, RST_NI=0): state IDLE, counter 0, all outputs 0. Takes effect immediately mid-sequence; a pending ESC and the held byte are lost.
- All outputs are registered. Every effect of an RX_VALID_I byte appears on the cycle after the strobe (latency 1).
- FSM states: IDLE, ESC_SEEN.
- IDLE, RX_VALID_I with byte != ESC: data byte is delivered to the holding register.
- IDLE, RX_VALID_I with byte == ESC: go to ESC_SEEN, counter := 0. No data is delivered.
- ESC_SEEN, RX_VALID_I with byte == ESC: literal ESC data byte is delivered; go to IDLE.
- ESC_SEEN, RX_VALID_I with byte != ESC: COMMAND_O := byte, COMMAND_VALID_O pulses for one cycle; go to IDLE. A command never touches the data holding register and never causes overrun.
- ESC_SEEN, no RX_VALID_I, timeout enabled:
  - counter increments each cycle;
  - when counter == TIMEOUT_CYCLES-1 and no RX_VALID_I that cycle: go to IDLE, pulse TIMEOUT_O, discard the ESC.
  - ESC_PENDING_O is therefore high for exactly TIMEOUT_CYCLES cycles. TIMEOUT_O is high in the first cycle ESC_PENDING_O is low.
  - A byte arriving on the terminal-count cycle is processed normally; no timeout.
- ESC_PENDING_O = (state == ESC_SEEN).
- Data delivery into the holding register:
  - If DATA_VALID_O=0, or READ_I=1 in the same cycle: DATA_REC_O := byte, DATA_VALID_O := 1.
  - Else: byte dropped, held byte kept, OVERRUN_O pulses.
- READ_I with DATA_VALID_O=1 and no delivery: DATA_VALID_O := 0. DATA_REC_O keeps its value.
- READ_I with DATA_VALID_O=0: ignored.
- RX_VALID_I is assumed to never assert on consecutive cycles for the same byte. Back-to-back strobes are still processed one byte per cycle.

Decomposition:
- Shared package dbg_uart_pkg holds:
  - the ESC default constant 8'hB1, shared with the transmitter;
  - typedef enum logic {IDLE, ESC_SEEN} rx_esc_state_e.
- No sub-module. The FSM, timeout counter and one-entry holding register fit in a single module.

Test Plan:
- Plain data: bytes 8'h41, 8'h42 with READ_I after each → DATA_REC_O=41 then 42, DATA_VALID_O rising one cycle after each strobe; no COMMAND_VALID_O.
- Escaped literal: B1, B1 → exactly one data byte B1 delivered; ESC_PENDING_O high between the strobes; no command.
- Command: B1, 8'h05 → COMMAND_O=05, COMMAND_VALID_O one-cycle pulse the cycle after the 05 strobe; DATA_VALID_O stays 0. Repeat with a held data byte present → no overrun.
- Overrun: 8'h10 unread, then 8'h20 without READ_I → OVERRUN_O pulse, DATA_REC_O stays 10. Then 8'h30 with READ_I in the same cycle → DATA_REC_O=30, no overrun.
- Timeout, TIMEOUT_CYCLES=8: lone B1 → ESC_PENDING_O high 8 cycles, then TIMEOUT_O pulse. Following 8'h05 → delivered as data, not command. Repeat with 05 on the terminal cycle → command, no timeout.
- Reset mid-sequence: B1, then RST_NI low for 1 cycle, then 8'h05 → all outputs 0 during reset; 05 delivered as data.
